// File: rtl/serial_tx_sequencer_if.sv
// serial_tx_sequencer_if
//   Read-port bundle between the TX sequencer and the 16x9 TX fifo.
//   fifo_empty       fifo empty flag
//   fifo_rd_data     9-bit word, valid the cycle after fifo_rd_request
//   fifo_rd_request  one-clock pop strobe
//   master = sequencer side, slave = fifo side.
interface serial_tx_sequencer_if;
   logic       fifo_empty;
   logic [8:0] fifo_rd_data;
   logic       fifo_rd_request;

   modport master (
      input  fifo_empty,
      input  fifo_rd_data,
      output fifo_rd_request
   );

   modport slave (
      output fifo_empty,
      output fifo_rd_data,
      input  fifo_rd_request
   );
endinterface

// File: rtl/serial_tx_sequencer.sv
// serial_tx_sequencer
//   Transmit controller for the serial IP. Pops 9-bit words from the TX fifo and
//   serialises them on tx: start bit, 5-8 data bits LSB first, optional parity or
//   word bit 8, then 1-2 stop bits. Bit timing uses a 24.8 fixed-point divisor.
// Ports
//   S_AXI_ACLK     clock
//   S_AXI_ARESETN  synchronous active-low reset
//   enable         1 = frames may start
//   brd            divisor: [31:8] integer clocks/bit, [7:0] fraction/256
//   data_bits      00=5 .. 11=8 data bits
//   parity_mode    00 none, 01 even, 10 odd, 11 word bit 8
//   stop2          1 = two stop bits
//   fifo           fifo read port (master side)
//   tx             serial line, idle high
//   busy           high whenever the sequencer is not idle
//   frame_done     one-clock pulse after the last stop bit
module serial_tx_sequencer (
   input  logic                         S_AXI_ACLK,
   input  logic                         S_AXI_ARESETN,
   input  logic                         enable,
   input  logic [31:0]                  brd,
   input  logic [1:0]                   data_bits,
   input  logic [1:0]                   parity_mode,
   input  logic                         stop2,
   serial_tx_sequencer_if.master        fifo,
   output logic                         tx,
   output logic                         busy,
   output logic                         frame_done
);

   typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;

   state_t      state_q, state_d;
   logic [8:0]  word_q, word_d;
   logic [1:0]  nbits_q, nbits_d;
   logic [1:0]  pmode_q, pmode_d;
   logic        stop2_q, stop2_d;
   logic [23:0] ibrd_q, ibrd_d;
   logic [7:0]  fbrd_q, fbrd_d;
   logic [7:0]  acc_q, acc_d;
   logic [24:0] cnt_q, cnt_d;
   logic [3:0]  idx_q, idx_d;
   logic        tx_q, tx_d;
   logic        rd_q, rd_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;

   logic [32:0] step_next, step_first;
   logic [7:0]  data_mask;
   logic        par_bit;
   logic        last_data;

   // Returns {new accumulator, clocks-1 for this bit}. Carry out of acc+fbrd
   // stretches the bit by one clock. A zero-length bit is only reachable if the
   // divisor was rewritten between IDLE and LOAD; it is held for one clock.
   function automatic logic [32:0] bit_step(input logic [23:0] ib,
                                            input logic [7:0]  fb,
                                            input logic [7:0]  ac);
      logic [8:0]  sum;
      logic [24:0] len;
      logic [24:0] cnt;
      sum = {1'b0, ac} + {1'b0, fb};
      len = {1'b0, ib} + {24'd0, sum[8]};
      cnt = (len == 25'd0) ? 25'd0 : len - 25'd1;
      return {sum[7:0], cnt};
   endfunction

   assign step_next  = bit_step(ibrd_q, fbrd_q, acc_q);
   assign step_first = bit_step(brd[31:8], brd[7:0], 8'd0);
   assign data_mask  = 8'hFF >> (2'd3 - nbits_q);
   // Odd parity is the even parity inverted; mode 11 sends word bit 8 verbatim.
   assign par_bit    = (pmode_q == 2'b11) ? word_q[8]
                                          : ((^(word_q[7:0] & data_mask)) ^ pmode_q[1]);
   assign last_data  = (idx_q == {2'b01, nbits_q});

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      nbits_d = nbits_q;
      pmode_d = pmode_q;
      stop2_d = stop2_q;
      ibrd_d  = ibrd_q;
      fbrd_d  = fbrd_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      tx_d    = tx_q;
      rd_d    = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (enable && !fifo.fifo_empty && (brd[31:8] != 24'd0)) begin
               state_d = POP;
               rd_d    = 1'b1;
            end
         end
         POP: state_d = LOAD;
         LOAD: begin
            // fifo data is valid in this cycle, so everything is captured on exit
            word_d           = fifo.fifo_rd_data;
            nbits_d          = data_bits;
            pmode_d          = parity_mode;
            stop2_d          = stop2;
            ibrd_d           = brd[31:8];
            fbrd_d           = brd[7:0];
            {acc_d, cnt_d}   = step_first;
            state_d          = START;
            tx_d             = 1'b0;
         end
         START: begin
            if (cnt_q == 25'd0) begin
               state_d        = DATA;
               idx_d          = 4'd0;
               tx_d           = word_q[0];
               {acc_d, cnt_d} = step_next;
            end else begin
               cnt_d = cnt_q - 25'd1;
            end
         end
         DATA: begin
            if (cnt_q == 25'd0) begin
               {acc_d, cnt_d} = step_next;
               if (!last_data) begin
                  idx_d = idx_q + 4'd1;
                  tx_d  = word_q[idx_q + 4'd1];
               end else if (pmode_q != 2'b00) begin
                  state_d = PARITY;
                  tx_d    = par_bit;
               end else begin
                  state_d = STOP;
                  idx_d   = 4'd0;
                  tx_d    = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 25'd1;
            end
         end
         PARITY: begin
            if (cnt_q == 25'd0) begin
               state_d        = STOP;
               idx_d          = 4'd0;
               tx_d           = 1'b1;
               {acc_d, cnt_d} = step_next;
            end else begin
               cnt_d = cnt_q - 25'd1;
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (cnt_q == 25'd0) begin
               if (stop2_q && (idx_q == 4'd0)) begin
                  idx_d          = 4'd1;
                  {acc_d, cnt_d} = step_next;
               end else begin
                  done_d = 1'b1;
                  if (enable && !fifo.fifo_empty) begin
                     state_d = POP;
                     rd_d    = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else begin
               cnt_d = cnt_q - 25'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state_q <= IDLE;
         word_q  <= '0;
         nbits_q <= '0;
         pmode_q <= '0;
         stop2_q <= 1'b0;
         ibrd_q  <= '0;
         fbrd_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
         rd_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         nbits_q <= nbits_d;
         pmode_q <= pmode_d;
         stop2_q <= stop2_d;
         ibrd_q  <= ibrd_d;
         fbrd_q  <= fbrd_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         rd_q    <= rd_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign tx                   = tx_q;
   assign busy                 = busy_q;
   assign frame_done           = done_q;
   assign fifo.fifo_rd_request = rd_q;

endmodule

// File: tb/tb_serial_tx_sequencer.sv
// tb_serial_tx_sequencer
//   Drives the sequencer from a behavioural fifo and checks every transmitted
//   frame against a model built from the framing rules: bit j of a frame ends
//   floor((j+1)*brd/256) clocks after the falling start edge.
module tb_serial_tx_sequencer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        enable;
   logic [31:0] brd;
   logic [1:0]  data_bits;
   logic [1:0]  parity_mode;
   logic        stop2;
   logic        tx;
   logic        busy;
   logic        frame_done;

   always #5 clk = ~clk;

   serial_tx_sequencer_if fifo_bus ();

   serial_tx_sequencer dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rstn),
      .enable        (enable),
      .brd           (brd),
      .data_bits     (data_bits),
      .parity_mode   (parity_mode),
      .stop2         (stop2),
      .fifo          (fifo_bus),
      .tx            (tx),
      .busy          (busy),
      .frame_done    (frame_done)
   );

   typedef struct {
      logic [11:0] bits;
      int          nb;
      longint      brd;
   } frame_t;

   int         tests = 0;
   int         fails = 0;
   frame_t     exp_q[$];
   logic [8:0] fq[$];
   int         pops = 0;
   bit         capturing = 1'b0;
   bit         mon_off = 1'b0;
   int         cyc = 0;
   int         start_cyc[$];
   int         end_cyc[$];

   task automatic check(input string name, input longint act, input longint req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic frame_t make_frame(input logic [8:0] w, input logic [1:0] db,
                                         input logic [1:0] pm, input logic s2,
                                         input logic [31:0] b);
      frame_t f;
      int n;
      int ones;
      n      = 5 + int'(db);
      ones   = 0;
      f.bits = '1;
      f.nb   = 0;
      f.bits[f.nb] = 1'b0;
      f.nb++;
      for (int i = 0; i < n; i++) begin
         f.bits[f.nb] = w[i];
         if (w[i]) ones++;
         f.nb++;
      end
      if (pm != 2'b00) begin
         if (pm == 2'b11)      f.bits[f.nb] = w[8];
         else if (pm == 2'b01) f.bits[f.nb] = (ones % 2 == 1);
         else                  f.bits[f.nb] = (ones % 2 == 0);
         f.nb++;
      end
      f.nb += s2 ? 2 : 1;
      f.brd = longint'(b);
      return f;
   endfunction

   function automatic int frame_len(input frame_t f);
      return int'((longint'(f.nb) * f.brd) >> 8);
   endfunction

   function automatic logic level(input frame_t f, input int t);
      for (int j = 0; j < f.nb; j++)
         if (longint'(t) < (((longint'(j) + 1) * f.brd) >> 8)) return f.bits[j];
      return 1'b1;
   endfunction

   task automatic push_frame(input logic [8:0] w);
      fq.push_back(w);
      exp_q.push_back(make_frame(w, data_bits, parity_mode, stop2, brd));
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((fq.size() != 0 || exp_q.size() != 0 || capturing || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({"drain_", name}, longint'(n < budget), 1);
      repeat (3) @(negedge clk);
   endtask

   // Behavioural fifo: a pop requested in cycle k delivers data in cycle k+1.
   initial begin
      bit pend;
      pend = 1'b0;
      fifo_bus.fifo_empty   = 1'b1;
      fifo_bus.fifo_rd_data = '0;
      forever begin
         @(posedge clk);
         #1;
         if (pend) begin
            pend = 1'b0;
            check("pop_only_when_nonempty", longint'(fq.size() != 0), 1);
            if (fq.size() != 0) begin
               fifo_bus.fifo_rd_data = fq.pop_front();
               pops++;
            end
         end
         if (fifo_bus.fifo_rd_request === 1'b1) pend = 1'b1;
         fifo_bus.fifo_empty = (fq.size() == 0);
      end
   end

   // Monitor: pops the expected frame when tx falls and compares the waveform.
   initial begin
      frame_t f;
      int     tl;
      int     mism;
      forever begin
         @(negedge clk);
         cyc++;
         if (!mon_off && !capturing) begin
            if (frame_done === 1'b1) check("spurious_frame_done", 1, 0);
            if (tx === 1'b0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", 1, 0);
                  while (tx === 1'b0) begin
                     @(negedge clk);
                     cyc++;
                  end
               end else begin
                  f         = exp_q.pop_front();
                  capturing = 1'b1;
                  tl        = frame_len(f);
                  mism      = 0;
                  start_cyc.push_back(cyc);
                  for (int t = 0; t < tl; t++) begin
                     if (t > 0) begin
                        @(negedge clk);
                        cyc++;
                     end
                     if (tx !== level(f, t) || busy !== 1'b1) mism++;
                  end
                  end_cyc.push_back(cyc);
                  check("frame_wave_mismatch_clocks", mism, 0);
                  @(negedge clk);
                  cyc++;
                  check("frame_done_after_stop", longint'(frame_done === 1'b1), 1);
                  capturing = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int         p0;
      int         n;
      int         lows;
      int         dones;
      logic [8:0] w;

      rstn        = 1'b0;
      enable      = 1'b1;
      brd         = 32'h0000_0A00;
      data_bits   = 2'b11;
      parity_mode = 2'b00;
      stop2       = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_tx", longint'(tx === 1'b1), 1);
      check("reset_busy", longint'(busy === 1'b0), 1);
      check("reset_rd_request", longint'(fifo_bus.fifo_rd_request === 1'b0), 1);
      check("reset_frame_done", longint'(frame_done === 1'b0), 1);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // 8N1, integer divisor 10
      p0 = pops;
      push_frame(9'h055);
      drain("t1", 400);
      check("t1_pops", pops - p0, 1);
      check("t1_frame_len", end_cyc[$] - start_cyc[$] + 1, 100);

      // fractional divisor 10.5
      brd = 32'h0000_0A80;
      push_frame(9'h0C3);
      drain("t2", 400);
      check("t2_frame_len", end_cyc[$] - start_cyc[$] + 1, 105);

      // parity variants
      brd = 32'h0000_0400;
      data_bits = 2'b10; parity_mode = 2'b01; stop2 = 1'b1;
      push_frame(9'h007);
      drain("t3_even", 400);
      parity_mode = 2'b10;
      push_frame(9'h007);
      drain("t3_odd", 400);
      data_bits = 2'b11; parity_mode = 2'b11; stop2 = 1'b0;
      push_frame(9'h1A5);
      drain("t3_bit8", 400);

      // back-to-back frames: two pops, two clocks of extra idle between
      parity_mode = 2'b00;
      p0 = pops;
      push_frame(9'h0F0);
      push_frame(9'h10F);
      drain("t4", 600);
      check("t4_pops", pops - p0, 2);
      check("t4_gap_after_stop", start_cyc[$] - end_cyc[end_cyc.size() - 2] - 1, 2);

      // enable dropped mid-frame
      brd = 32'h0000_0800;
      p0 = pops;
      push_frame(9'h03C);
      fq.push_back(9'h0AA);
      n = 0;
      while (!capturing && n < 100) begin @(negedge clk); n++; end
      check("t5_frame_started", longint'(n < 100), 1);
      repeat (20) @(negedge clk);
      enable = 1'b0;
      n = 0;
      while ((capturing || busy) && n < 300) begin @(negedge clk); n++; end
      check("t5_frame_completed", longint'(n < 300), 1);
      repeat (50) @(negedge clk);
      check("t5_busy_low", longint'(busy === 1'b0), 1);
      check("t5_single_pop", pops - p0, 1);
      check("t5_word_left", fq.size(), 1);
      exp_q.push_back(make_frame(9'h0AA, data_bits, parity_mode, stop2, brd));
      enable = 1'b1;
      drain("t5_resume", 400);

      // reset during DATA abandons the frame
      mon_off = 1'b1;
      fq.push_back(9'h0E1);
      n = 0;
      while (tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      check("t5r_frame_started", longint'(n < 100), 1);
      repeat (25) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check("t5r_tx_high", longint'(tx === 1'b1), 1);
      check("t5r_busy_low", longint'(busy === 1'b0), 1);
      check("t5r_no_done", longint'(frame_done === 1'b0), 1);
      rstn = 1'b1;
      lows = 0; dones = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
         if (frame_done !== 1'b0) dones++;
      end
      check("t5r_idle_low_clocks", lows, 0);
      check("t5r_done_pulses", dones, 0);
      mon_off = 1'b0;

      // ibrd == 0 never starts a frame
      brd = 32'h0000_00FF;
      p0 = pops;
      fq.push_back(9'h123);
      lows = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("t6_no_pop", pops - p0, 0);
      check("t6_tx_low_clocks", lows, 0);
      check("t6_busy_low", longint'(busy === 1'b0), 1);
      brd = 32'h0000_0300;
      exp_q.push_back(make_frame(9'h123, data_bits, parity_mode, stop2, brd));
      drain("t6_release", 400);

      // randomized configurations and words
      for (int it = 0; it < 25; it++) begin
         brd         = (32'($urandom_range(1, 6)) << 8) | 32'($urandom_range(0, 255));
         data_bits   = 2'($urandom_range(0, 3));
         parity_mode = 2'($urandom_range(0, 3));
         stop2       = 1'($urandom_range(0, 1));
         n           = int'($urandom_range(1, 3));
         for (int k = 0; k < n; k++) begin
            w = 9'($urandom_range(0, 511));
            push_frame(w);
         end
         drain("rand", 1000);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
